// File: rtl/game_core.sv
// game_core: bar-dodging game engine.
// A one-hot bar falls from the top row to the player row. Each time it passes
// the player row it respawns at the top, and a new gap lane is drawn from an
// 8-bit LFSR. When the player's lane is not the gap lane, the player loses a
// life. The score counts score ticks while the game is running. The bar speeds
// up every LVL_TICKS score ticks.
//
// Ports:
//   gameclk   - clock, all logic on the rising edge
//   clr       - synchronous active-low reset
//   step_en   - game tick that advances the move counter
//   score_en  - score tick
//   start     - begin a game from IDLE, or restart from OVER
//   plrpos    - player lane
//   barpos    - one-hot bar row (bit NROW-1 is the top row, bit 0 is the player row)
//   holepos   - gap lane of the current bar
//   timealive - saturating survival score
//   lives     - remaining lives
//   hit       - one-cycle pulse when a life is lost
//   game_over - high while in OVER
//
// state | meaning
// IDLE  | waiting for start; ticks ignored
// PLAY  | bar moving, score counting
// OVER  | lives exhausted; outputs frozen until start
module game_core #(
  parameter int          NCOL      = 16,
  parameter int          NROW      = 9,
  parameter int          LIVES     = 3,
  parameter int          SCORE_W   = 16,
  parameter int          SPD_INIT  = 4,
  parameter int          LVL_TICKS = 32,
  parameter logic [7:0]  SEED      = 8'hA5,
  parameter int          HOLE_W    = $clog2(NCOL)
) (
  input  logic               gameclk,
  input  logic               clr,
  input  logic               step_en,
  input  logic               score_en,
  input  logic               start,
  input  logic [HOLE_W-1:0]  plrpos,
  output logic [NROW-1:0]    barpos,
  output logic [HOLE_W-1:0]  holepos,
  output logic [SCORE_W-1:0] timealive,
  output logic [2:0]         lives,
  output logic               hit,
  output logic               game_over
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  localparam int LW = $clog2(LVL_TICKS + 1);
  localparam logic [LW-1:0]     LVL_LOAD   = LW'(LVL_TICKS - 1);
  localparam logic [HOLE_W-1:0] NCOL_N     = HOLE_W'(NCOL);
  localparam logic [NROW-1:0]   BAR_TOP    = {1'b1, {(NROW-1){1'b0}}};
  localparam logic [2:0]        LIVES_INIT = 3'(LIVES);
  localparam logic [3:0]        SPD0       = 4'(SPD_INIT);

  // The gap lane comes from the low LFSR bits. Values past the last lane fold
  // back once. This is enough because the value is below 2*NCOL.
  function automatic logic [HOLE_W-1:0] hole_of(input logic [7:0] l);
    if (int'(l[HOLE_W-1:0]) >= NCOL)
      return l[HOLE_W-1:0] - NCOL_N;
    return l[HOLE_W-1:0];
  endfunction

  localparam logic [HOLE_W-1:0] HOLE_SEED = hole_of(SEED);

  state_t          state;
  logic [7:0]      lfsr;
  logic [7:0]      lfsr_nx;
  logic [3:0]      mcnt;
  logic [3:0]      level;
  logic [3:0]      spd;
  logic [LW-1:0]   lvl_cnt;
  logic            adv;
  logic            coll;

  assign lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // spd is based on the registered level. A level change in this cycle
  // therefore takes effect from the next step.
  always_comb begin
    spd = 4'd1;
    if (level < SPD0)
      spd = SPD0 - level;
  end

  // After a speed-up the count can already be past the new limit.
  // In that case the next step advances the bar.
  assign adv  = step_en && (mcnt >= spd - 4'd1);
  assign coll = (plrpos != holepos) || (int'(plrpos) >= NCOL);

  always_ff @(posedge gameclk) begin
    if (!clr || (state == OVER && start)) begin
      barpos    <= BAR_TOP;
      holepos   <= HOLE_SEED;
      timealive <= '0;
      lives     <= LIVES_INIT;
      level     <= 4'd0;
      mcnt      <= 4'd0;
      lvl_cnt   <= LVL_LOAD;
      hit       <= 1'b0;
      game_over <= 1'b0;
      state     <= clr ? PLAY : IDLE;
      // A restart keeps the LFSR running so that consecutive games differ.
      if (!clr)
        lfsr <= SEED;
    end else begin
      hit <= 1'b0;
      case (state)
        IDLE: begin
          if (start)
            state <= PLAY;
        end
        PLAY: begin
          if (step_en) begin
            if (adv) begin
              mcnt <= 4'd0;
              if (barpos[0]) begin
                barpos  <= BAR_TOP;
                lfsr    <= lfsr_nx;
                holepos <= hole_of(lfsr_nx);
                if (coll) begin
                  lives <= lives - 3'd1;
                  hit   <= 1'b1;
                  if (lives == 3'd1) begin
                    state     <= OVER;
                    game_over <= 1'b1;
                  end
                end
              end else begin
                barpos <= barpos >> 1;
              end
            end else begin
              mcnt <= mcnt + 4'd1;
            end
          end
          // Score ticks stop counting once the score saturates, so the level
          // also stops changing from that point.
          if (score_en && timealive != '1) begin
            timealive <= timealive + SCORE_W'(1);
            if (lvl_cnt == '0) begin
              lvl_cnt <= LVL_LOAD;
              if (level != 4'hF)
                level <= level + 4'd1;
            end else begin
              lvl_cnt <= lvl_cnt - LW'(1);
            end
          end
        end
        OVER: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_core.sv
module tb_game_core;

  logic gameclk = 1'b0;
  always #5 gameclk = ~gameclk;

  logic clr, step_en, score_en, start;
  logic [3:0] plr_d, plr_o;

  logic [8:0]  d_bar, o_bar, s_bar;
  logic [3:0]  d_hole, o_hole, s_hole;
  logic [15:0] d_time, o_time;
  logic [5:0]  s_time;
  logic [2:0]  d_lives, o_lives, s_lives;
  logic        d_hit, o_hit, s_hit, d_go, o_go, s_go;

  game_core u_dut (
    .gameclk(gameclk), .clr(clr), .step_en(step_en), .score_en(score_en), .start(start),
    .plrpos(plr_d), .barpos(d_bar), .holepos(d_hole), .timealive(d_time),
    .lives(d_lives), .hit(d_hit), .game_over(d_go));

  game_core #(.NCOL(12), .LIVES(1)) u_ovr (
    .gameclk(gameclk), .clr(clr), .step_en(step_en), .score_en(score_en), .start(start),
    .plrpos(plr_o), .barpos(o_bar), .holepos(o_hole), .timealive(o_time),
    .lives(o_lives), .hit(o_hit), .game_over(o_go));

  game_core #(.SCORE_W(6)) u_spd (
    .gameclk(gameclk), .clr(clr), .step_en(step_en), .score_en(score_en), .start(start),
    .plrpos(plr_d), .barpos(s_bar), .holepos(s_hole), .timealive(s_time),
    .lives(s_lives), .hit(s_hit), .game_over(s_go));

  typedef struct packed {
    logic [8:0]  bar;
    logic [3:0]  hole;
    logic [15:0] ta;
    logic [2:0]  lv;
    logic        hit;
    logic        go;
  } snap_t;

  snap_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int hits;

  // Reference model of the default-parameter instance.
  int         m_st;   // 0 idle, 1 play, 2 over
  int         m_row, m_cnt, m_lives, m_time, m_level;
  logic [7:0] m_lfsr;
  logic [3:0] m_hole;
  logic       m_hit;

  function automatic logic [7:0] lfsr_nx(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic model_init();
    m_row = 8; m_hole = 4'd5; m_time = 0; m_lives = 3; m_level = 0; m_cnt = 0;
  endtask

  task automatic model_apply();
    int spd;
    bit coll;
    m_hit = 1'b0;
    if (!clr) begin
      m_st = 0; m_lfsr = 8'hA5; model_init();
    end else if (m_st == 2 && start) begin
      model_init(); m_st = 1;
    end else if (m_st == 0) begin
      if (start) m_st = 1;
    end else if (m_st == 1) begin
      spd = (4 - m_level < 1) ? 1 : 4 - m_level;
      if (step_en) begin
        if (m_cnt >= spd - 1) begin
          m_cnt = 0;
          if (m_row > 0) m_row--;
          else begin
            coll = (plr_d != m_hole);
            m_row = 8;
            m_lfsr = lfsr_nx(m_lfsr);
            m_hole = m_lfsr[3:0];
            if (coll) begin
              m_lives--; m_hit = 1'b1;
              if (m_lives == 0) m_st = 2;
            end
          end
        end else m_cnt++;
      end
      if (score_en && m_time < 65535) begin
        m_time++;
        if (m_time % 32 == 0) m_level++;
      end
    end
  endtask

  task automatic cycle(input bit c, input bit st, input bit se, input bit sc);
    snap_t e, obs;
    clr = c; start = st; step_en = se; score_en = sc;
    model_apply();
    exp_q.push_back('{bar: 9'(1 << m_row), hole: m_hole, ta: 16'(m_time),
                      lv: 3'(m_lives), hit: m_hit, go: (m_st == 2)});
    @(posedge gameclk); #1;
    e = exp_q.pop_front();
    obs = '{bar: d_bar, hole: d_hole, ta: d_time, lv: d_lives, hit: d_hit, go: d_go};
    n_vec++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL snapshot t=%0t got bar=%h hole=%h ta=%0d lv=%0d hit=%b go=%b want bar=%h hole=%h ta=%0d lv=%0d hit=%b go=%b",
               $time, obs.bar, obs.hole, obs.ta, obs.lv, obs.hit, obs.go,
               e.bar, e.hole, e.ta, e.lv, e.hit, e.go);
    end
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    plr_d = 4'd5; plr_o = 4'd5;
    do_reset();
    n_vec++; if (d_bar !== 9'h100) begin n_err++; $display("FAIL reset_bar got %h want 100", d_bar); end
    n_vec++; if (d_hole !== 4'd5) begin n_err++; $display("FAIL reset_hole got %0d want 5", d_hole); end
    n_vec++; if (d_lives !== 3'd3) begin n_err++; $display("FAIL reset_lives got %0d want 3", d_lives); end
    n_vec++; if (d_time !== 16'd0) begin n_err++; $display("FAIL reset_time got %0d want 0", d_time); end
    n_vec++; if (d_go !== 1'b0) begin n_err++; $display("FAIL reset_go got %b want 0", d_go); end
    n_vec++; if (o_lives !== 3'd1) begin n_err++; $display("FAIL reset_ovr_lives got %0d want 1", o_lives); end
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 1);
    n_vec++; if (d_time !== 16'd0 || d_bar !== 9'h100) begin
      n_err++; $display("FAIL idle_ignore got time=%0d bar=%h want 0 100", d_time, d_bar);
    end
  endtask

  task automatic test_safe_pass();
    plr_d = 4'd5; plr_o = 4'd5;
    cycle(1, 1, 0, 0);
    hits = 0;
    for (int i = 0; i < 36; i++) begin
      cycle(1, 0, 1, 0);
      if (d_hit) hits++;
    end
    n_vec++; if (hits !== 0) begin n_err++; $display("FAIL safe_hits got %0d want 0", hits); end
    n_vec++; if (d_bar !== 9'h100) begin n_err++; $display("FAIL safe_bar got %h want 100", d_bar); end
    n_vec++; if (d_lives !== 3'd3) begin n_err++; $display("FAIL safe_lives got %0d want 3", d_lives); end
    n_vec++; if (d_hole !== 4'hA) begin n_err++; $display("FAIL safe_hole got %h want a", d_hole); end
  endtask

  task automatic test_miss();
    plr_d = 4'd3; plr_o = 4'd10;
    hits = 0;
    for (int i = 0; i < 36; i++) begin
      cycle(1, 0, 1, 0);
      if (d_hit) hits++;
    end
    n_vec++; if (hits !== 1) begin n_err++; $display("FAIL miss_hits got %0d want 1", hits); end
    n_vec++; if (d_lives !== 3'd2) begin n_err++; $display("FAIL miss_lives got %0d want 2", d_lives); end
    n_vec++; if (d_hole !== 4'd5) begin n_err++; $display("FAIL miss_hole got %0d want 5", d_hole); end
  endtask

  task automatic test_game_over();
    plr_d = 4'd5; plr_o = 4'd13;
    do_reset();
    cycle(1, 1, 0, 0);
    hits = 0;
    for (int i = 0; i < 36; i++) begin
      cycle(1, 0, 1, 0);
      if (o_hit) hits++;
    end
    n_vec++; if (hits !== 1) begin n_err++; $display("FAIL over_hits got %0d want 1", hits); end
    n_vec++; if (o_go !== 1'b1) begin n_err++; $display("FAIL over_go got %b want 1", o_go); end
    n_vec++; if (o_lives !== 3'd0) begin n_err++; $display("FAIL over_lives got %0d want 0", o_lives); end
    n_vec++; if (o_bar !== 9'h100) begin n_err++; $display("FAIL over_bar got %h want 100", o_bar); end
    n_vec++; if (o_hole !== 4'd10) begin n_err++; $display("FAIL over_hole got %0d want 10", o_hole); end
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 1);
    n_vec++; if ({o_bar, o_hole, o_time, o_lives, o_hit, o_go} !== {9'h100, 4'd10, 16'd0, 3'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL over_hold got bar=%h hole=%0d time=%0d lives=%0d hit=%b go=%b want 100 10 0 0 0 1",
                        o_bar, o_hole, o_time, o_lives, o_hit, o_go);
    end
    cycle(1, 1, 0, 0);
    n_vec++; if ({o_go, o_lives, o_bar, o_time} !== {1'b0, 3'd1, 9'h100, 16'd0}) begin
      n_err++; $display("FAIL over_restart got go=%b lives=%0d bar=%h time=%0d want 0 1 100 0", o_go, o_lives, o_bar, o_time);
    end
  endtask

  task automatic test_speed_sat();
    plr_d = 4'd5; plr_o = 4'd5;
    do_reset();
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 32; i++) cycle(1, 0, 0, 1);
    n_vec++; if (s_time !== 6'd32) begin n_err++; $display("FAIL spd_time32 got %0d want 32", s_time); end
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    n_vec++; if (s_bar !== 9'h100) begin n_err++; $display("FAIL spd_bar2 got %h want 100", s_bar); end
    cycle(1, 0, 1, 0);
    n_vec++; if (s_bar !== 9'h080) begin n_err++; $display("FAIL spd_bar3 got %h want 080", s_bar); end
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0);
    n_vec++; if (s_bar !== 9'h040) begin n_err++; $display("FAIL spd_bar6 got %h want 040", s_bar); end
    for (int i = 0; i < 100; i++) cycle(1, 0, 0, 1);
    n_vec++; if (s_time !== 6'd63) begin n_err++; $display("FAIL spd_sat got %0d want 63", s_time); end
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1);
    n_vec++; if (s_time !== 6'd63) begin n_err++; $display("FAIL spd_sat_hold got %0d want 63", s_time); end
  endtask

  task automatic test_back_to_back();
    plr_d = 4'd5; plr_o = 4'd5;
    do_reset();
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 22; i++) cycle(1, 0, 1, 0);
    n_vec++; if (d_bar !== 9'h008) begin n_err++; $display("FAIL mid_bar got %h want 008", d_bar); end
    cycle(0, 1, 1, 1);
    n_vec++; if ({d_bar, d_hole, d_time, d_lives, d_go} !== {9'h100, 4'd5, 16'd0, 3'd3, 1'b0}) begin
      n_err++; $display("FAIL mid_reset got bar=%h hole=%0d time=%0d lives=%0d go=%b want 100 5 0 3 0",
                        d_bar, d_hole, d_time, d_lives, d_go);
    end
    cycle(1, 1, 0, 0);
    cycle(1, 0, 1, 1);
    n_vec++; if (d_time !== 16'd1) begin n_err++; $display("FAIL both_time got %0d want 1", d_time); end
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    n_vec++; if (d_bar !== 9'h100) begin n_err++; $display("FAIL both_bar3 got %h want 100", d_bar); end
    cycle(1, 0, 1, 0);
    n_vec++; if (d_bar !== 9'h080) begin n_err++; $display("FAIL both_bar4 got %h want 080", d_bar); end
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; step_en = 1'b0; score_en = 1'b0;
    plr_d = 4'd0; plr_o = 4'd0;
    test_reset();
    test_safe_pass();
    test_miss();
    test_game_over();
    test_speed_sat();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
